// File: rtl/shift_frame_pkg.sv
// Shared definitions for the serial frame controller: state encoding and
// default geometry.
package shift_frame_pkg;

  localparam int N_DEFAULT   = 16;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/Register.sv
// Generic n-bit parallel-load, left-shift register with synchronous
// active-high clear. Priority: reset > Load > Shift.
module Register #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Load,
  input  logic         Shift,
  input  logic         Shift_In,
  input  logic [n-1:0] Din,
  output logic [n-1:0] Dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Dout <= '0;
    end else if (Load) begin
      Dout <= Din;
    end else if (Shift) begin
      Dout <= {Dout[n-2:0], Shift_In};
    end
  end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame controller: accepts a parallel word, shifts it out MSB first while
// shifting sin in, one bit every DIV clocks, then presents the received word.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         abort,
  input  logic         sin,
  output logic         sout,
  output logic         frame,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [1:0]   dbg_state
);

  // Handshake: a word is taken on a rising edge where in_valid && in_ready
  // && !abort; in_ready is high only in IDLE, so in_valid elsewhere is ignored.

  localparam int BW = $clog2(N) + 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  sreg;
  logic          load;
  logic          tick;
  logic          last_tick;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tick       = 1'b0;
    last_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        tick      = (div_cnt == DIV_LAST);
        last_tick = tick && (bit_cnt == BIT_LAST);
        if (last_tick) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      if (load || abort || state != SHIFT) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) bit_cnt <= bit_cnt + BW'(1);
      end
      // Capture the word including the bit sampled on the final tick.
      if (last_tick && !abort) out_data <= {sreg[N-2:0], sin};
    end
  end

  Register #(.n(N)) u_sreg (
    .clk      (clk),
    .reset    (!reset_n || abort),
    .Load     (load),
    .Shift    (tick),
    .Shift_In (sin),
    .Din      (in_data),
    .Dout     (sreg)
  );

  assign in_ready  = (state == IDLE);
  assign frame     = (state == SHIFT);
  assign sout      = frame & sreg[N-1];
  assign out_valid = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed and randomized bench for shift_frame_ctrl, checked against a
// bit-index model of the serial frame (one bit per DIV cycles, MSB first).
module tb_shift_frame_ctrl;

  localparam int TN = 16;
  localparam int TD = 4;
  localparam int BN = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // DUT a: N=16, DIV=4
  logic          in_valid = 1'b0, abort = 1'b0, sin = 1'b0;
  logic [TN-1:0] in_data = '0;
  logic          in_ready, sout, frame, out_valid;
  logic [TN-1:0] out_data;
  logic [1:0]    dbg_state;

  shift_frame_ctrl #(.N(TN), .DIV(TD)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .sin(sin), .sout(sout), .frame(frame),
    .out_valid(out_valid), .out_data(out_data), .dbg_state(dbg_state)
  );

  // DUT b: N=8, DIV=1
  logic          b_in_valid = 1'b0, b_abort = 1'b0, b_sin = 1'b0;
  logic [BN-1:0] b_in_data = '0;
  logic          b_in_ready, b_sout, b_frame, b_out_valid;
  logic [BN-1:0] b_out_data;
  logic [1:0]    b_dbg_state;

  shift_frame_ctrl #(.N(BN), .DIV(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .abort(b_abort), .sin(b_sin), .sout(b_sout), .frame(b_frame),
    .out_valid(b_out_valid), .out_data(b_out_data), .dbg_state(b_dbg_state)
  );

  // Scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic [TN-1:0] exp_q[$];
  logic [TN-1:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_frame", frame, 1'b0);
      check("idle_sout", sout, 1'b0);
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_out_hold", out_data, last_out);
    end
  endtask

  // cut_kind: 0 none, 1 abort during cycle cut_cycle, 2 reset pulse in that cycle
  task automatic run_frame(input logic [TN-1:0] din, input logic [TN-1:0] sinw,
                           input int cut_kind, input int cut_cycle, input bit hold_valid);
    int k;
    @(negedge clk);
    check("accept_ready", in_ready, 1'b1);
    check("accept_frame", frame, 1'b0);
    check("accept_sout", sout, 1'b0);
    in_valid = 1'b1;
    in_data  = din;
    abort    = 1'b0;
    sin      = 1'b0;
    for (int c = 1; c <= TN * TD; c++) begin
      @(negedge clk);
      k = (c - 1) / TD;
      check("shift_frame", frame, 1'b1);
      check("shift_ready", in_ready, 1'b0);
      check("shift_out_valid", out_valid, 1'b0);
      check("shift_sout", sout, din[TN-1-k]);
      check("shift_out_hold", out_data, last_out);
      in_valid = hold_valid;
      in_data  = TN'($urandom);
      sin      = sinw[TN-1-k];
      if (cut_kind == 1 && c == cut_cycle) begin
        abort = 1'b1;
        @(negedge clk);
        check("abort_state", dbg_state, 2'b00);
        check("abort_frame", frame, 1'b0);
        check("abort_sout", sout, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_hold", out_data, last_out);
        abort    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (cut_kind == 2 && c == cut_cycle) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_frame", frame, 1'b0);
        check("rst_sout", sout, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_state", dbg_state, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_frame", frame, 1'b0);
        reset_n  = 1'b1;
        last_out = '0;
        return;
      end
    end
    @(negedge clk);
    exp_q.push_back(sinw);
    check("done_out_valid", out_valid, 1'b1);
    check("done_out_data", out_data, exp_q.pop_front());
    check("done_frame", frame, 1'b0);
    check("done_ready", in_ready, 1'b0);
    check("done_sout", sout, 1'b0);
    last_out = sinw;
    in_valid = hold_valid;
    in_data  = TN'($urandom);
  endtask

  task automatic run_b(input logic [BN-1:0] din, input logic [BN-1:0] sinw);
    @(negedge clk);
    check("b_ready", b_in_ready, 1'b1);
    b_in_valid = 1'b1;
    b_in_data  = din;
    for (int c = 1; c <= BN; c++) begin
      @(negedge clk);
      check("b_frame", b_frame, 1'b1);
      check("b_out_valid_low", b_out_valid, 1'b0);
      check("b_sout", b_sout, din[BN-c]);
      b_in_valid = 1'b0;
      b_sin      = sinw[BN-c];
    end
    @(negedge clk);
    check("b_out_valid", b_out_valid, 1'b1);
    check("b_out_data", b_out_data, sinw);
    check("b_done_frame", b_frame, 1'b0);
    @(negedge clk);
    check("b_pulse_end", b_out_valid, 1'b0);
    check("b_out_hold", b_out_data, sinw);
  endtask

  initial begin
    bit hold;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", dbg_state, 2'b00);
    check("reset_frame", frame, 1'b0);
    check("reset_sout", sout, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_ready", in_ready, 1'b1);
    check("reset_b_out_data", b_out_data, '0);
    reset_n = 1'b1;

    // Directed frame with known data
    run_frame(16'hA5C3, 16'h3C5A, 0, 0, 1'b0);
    idle(2);

    // Back-to-back frames with in_valid held high
    run_frame(16'h0001, TN'($urandom), 0, 0, 1'b1);
    run_frame(16'h8000, TN'($urandom), 0, 0, 1'b0);
    idle(1);

    // Abort on the 7th tick, then a normal frame
    run_frame(TN'($urandom), TN'($urandom), 1, 7 * TD, 1'b0);
    idle(2);
    run_frame(TN'($urandom), TN'($urandom), 0, 0, 1'b0);
    idle(1);

    // abort and in_valid together in IDLE: no accept
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    check("abort_idle_state", dbg_state, 2'b00);
    check("abort_idle_frame", frame, 1'b0);
    check("abort_idle_ready", in_ready, 1'b1);
    abort = 1'b0;
    idle(1);

    // Reset pulse mid-SHIFT
    run_frame(TN'($urandom), TN'($urandom), 2, $urandom_range(5, 50), 1'b0);
    idle(3);

    // DIV=1, N=8 instance
    run_b(8'hFF, 8'h00);
    run_b(BN'($urandom), BN'($urandom));

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      hold = 1'($urandom_range(0, 1));
      run_frame(TN'($urandom), TN'($urandom), 0, 0, hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
